// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Holds FSM states, funct3/wbsel encodings, the MEM/WB bundle and lane helpers.
package memory_stage_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_MEM  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    typedef struct packed {
        logic        regwrite;
        logic [1:0]  wbsel;
        logic [4:0]  rd;
        logic [31:0] data_read;
        logic [31:0] alures;
        logic [31:0] pc4;
        logic        misalign;
        logic        buserr;
    } mem_wb_t;

    localparam mem_wb_t MW_BUBBLE = '{
        regwrite:  1'b0,
        wbsel:     WB_NONE,
        rd:        5'd0,
        data_read: 32'd0,
        alures:    32'd0,
        pc4:       32'd0,
        misalign:  1'b0,
        buserr:    1'b0
    };

    // funct3[1:0] gives the access size for both loads and stores;
    // 2'b11 falls into the word case.
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        if (f3[1:0] == F3_B[1:0])
            return 1'b0;
        else if (f3[1:0] == F3_H[1:0])
            return off[0];
        else
            return (off != 2'b00);
    endfunction

    function automatic logic [3:0] byte_enable(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        if (f3[1:0] == F3_B[1:0])
            return 4'b0001 << off;
        else if (f3[1:0] == F3_H[1:0])
            return 4'b0011 << off;
        else
            return 4'b1111;
    endfunction

    function automatic logic [31:0] store_lanes(
        input logic [2:0]  f3,
        input logic [31:0] wd
    );
        if (f3[1:0] == F3_B[1:0])
            return {4{wd[7:0]}};
        else if (f3[1:0] == F3_H[1:0])
            return {2{wd[15:0]}};
        else
            return wd;
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word.
// Ports: i_rdata (raw word), i_off (addr[1:0]), i_funct3 (load kind) -> o_data.
module load_align
    import memory_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    // Word accesses are always aligned here, so the shift is a no-op for them.
    assign w_shift = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shift;
        unique case (i_funct3)
            F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   o_data = {24'd0, w_shift[7:0]};
            F3_HU:   o_data = {16'd0, w_shift[15:0]};
            F3_W:    o_data = w_shift;
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: data-memory handshake, wait/timeout FSM, MEM/WB register.
// Ports: M-stage control/data in, dmem request/response, stallM, registered W fields.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        regwriteM,
    input  logic [1:0]  wbselM,
    input  logic [4:0]  rdM,
    input  logic        memwriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUresM,
    input  logic [31:0] writedataM,
    input  logic [31:0] pc4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stallM,
    output logic        regwriteW,
    output logic [1:0]  wbselW,
    output logic [4:0]  rdW,
    output logic [31:0] data_readW,
    output logic [31:0] ALUresW,
    output logic [31:0] pc4W,
    output logic        misalignW,
    output logic        buserrW
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    mem_wb_t     r_w;

    logic        w_load;
    logic        w_store;
    logic        w_mem;
    logic        w_misalign;
    logic        w_wait;
    logic        w_issue;
    logic        w_timeout;
    logic [31:0] w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;
    mem_wb_t     w_next;

    assign w_load     = regwriteM && (wbselM == WB_MEM);
    assign w_store    = memwriteM;
    assign w_mem      = w_load || w_store;
    assign w_misalign = w_mem && is_misaligned(funct3M, ALUresM[1:0]);
    assign w_wait     = (r_state == S_WAIT);
    assign w_issue    = !w_wait && w_mem && !w_misalign;

    assign w_addr  = {ALUresM[31:2], 2'b00};
    assign w_be    = byte_enable(funct3M, ALUresM[1:0]);
    assign w_wdata = store_lanes(funct3M, writedataM);

    // While waiting, the memory sees the request captured at issue time.
    assign dmem_req   = !rst && (w_wait || w_issue);
    assign dmem_we    = w_wait ? r_we    : w_store;
    assign dmem_addr  = w_wait ? r_addr  : w_addr;
    assign dmem_be    = w_wait ? r_be    : w_be;
    assign dmem_wdata = w_wait ? r_wdata : w_wdata;

    // Ready in the last allowed cycle counts as a normal completion.
    assign w_timeout = w_wait && !dmem_ready && (r_cnt == CNT_LAST);
    assign stallM    = dmem_req && !dmem_ready && !w_timeout;

    load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_off    (ALUresM[1:0]),
        .i_funct3 (funct3M),
        .o_data   (w_ldata)
    );

    always_comb begin
        w_next = MW_BUBBLE;
        if (stallM) begin
            w_next = MW_BUBBLE;
        end else if (w_timeout) begin
            w_next.buserr = 1'b1;
        end else if (w_misalign) begin
            w_next.misalign = 1'b1;
        end else begin
            w_next.regwrite  = regwriteM;
            w_next.wbsel     = wbselM;
            w_next.rd        = rdM;
            w_next.data_read = w_load ? w_ldata : 32'd0;
            w_next.alures    = ALUresM;
            w_next.pc4       = pc4M;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_w     <= '0;
        end else begin
            r_w <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_issue && !dmem_ready) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_we    <= w_store;
                        r_addr  <= w_addr;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || w_timeout) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign regwriteW  = r_w.regwrite;
    assign wbselW     = r_w.wbsel;
    assign rdW        = r_w.rd;
    assign data_readW = r_w.data_read;
    assign ALUresW    = r_w.alures;
    assign pc4W       = r_w.pc4;
    assign misalignW  = r_w.misalign;
    assign buserrW    = r_w.buserr;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage.
// Table of single-cycle accesses plus directed wait/timeout/reset sequences.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteM;
    logic [1:0]  wbselM;
    logic [4:0]  rdM;
    logic        memwriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUresM;
    logic [31:0] writedataM;
    logic [31:0] pc4M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stallM;
    logic        regwriteW;
    logic [1:0]  wbselW;
    logic [4:0]  rdW;
    logic [31:0] data_readW;
    logic [31:0] ALUresW;
    logic [31:0] pc4W;
    logic        misalignW;
    logic        buserrW;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .regwriteM  (regwriteM),
        .wbselM     (wbselM),
        .rdM        (rdM),
        .memwriteM  (memwriteM),
        .funct3M    (funct3M),
        .ALUresM    (ALUresM),
        .writedataM (writedataM),
        .pc4M       (pc4M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .stallM     (stallM),
        .regwriteW  (regwriteW),
        .wbselW     (wbselW),
        .rdW        (rdW),
        .data_readW (data_readW),
        .ALUresW    (ALUresW),
        .pc4W       (pc4W),
        .misalignW  (misalignW),
        .buserrW    (buserrW)
    );

    typedef struct packed {
        logic        rw;
        logic [1:0]  wb;
        logic [4:0]  rd;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rw;
        logic [1:0]  e_wb;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] e_alu;
        logic [31:0] e_pc4;
        logic        e_mis;
    } vec_t;

    vec_t v[16];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic set_m(input logic rw, input logic [1:0] wb,
                         input logic [4:0] rd, input logic mw,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4);
        regwriteM  = rw;
        wbselM     = wb;
        rdM        = rd;
        memwriteM  = mw;
        funct3M    = f3;
        ALUresM    = alu;
        writedataM = wd;
        pc4M       = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        int bubbles;
        int cnt;
        bit got;

        v[0]  = '{1'b1, 2'b00, 5'd5, 1'b0, 3'b010, 32'h100, 32'h0, 32'h104, 32'hDEADBEEF,
                  1'b1, 1'b0, 32'h100, 4'hF, 32'h0,
                  1'b1, 2'b00, 5'd5, 32'hDEADBEEF, 32'h100, 32'h104, 1'b0};
        v[1]  = '{1'b1, 2'b00, 5'd6, 1'b0, 3'b000, 32'h103, 32'h0, 32'h108, 32'h80112233,
                  1'b1, 1'b0, 32'h100, 4'h8, 32'h0,
                  1'b1, 2'b00, 5'd6, 32'hFFFFFF80, 32'h103, 32'h108, 1'b0};
        v[2]  = '{1'b1, 2'b00, 5'd7, 1'b0, 3'b100, 32'h103, 32'h0, 32'h10C, 32'h80112233,
                  1'b1, 1'b0, 32'h100, 4'h8, 32'h0,
                  1'b1, 2'b00, 5'd7, 32'h00000080, 32'h103, 32'h10C, 1'b0};
        v[3]  = '{1'b1, 2'b00, 5'd8, 1'b0, 3'b001, 32'h102, 32'h0, 32'h110, 32'h80112233,
                  1'b1, 1'b0, 32'h100, 4'hC, 32'h0,
                  1'b1, 2'b00, 5'd8, 32'hFFFF8011, 32'h102, 32'h110, 1'b0};
        v[4]  = '{1'b1, 2'b00, 5'd9, 1'b0, 3'b101, 32'h102, 32'h0, 32'h114, 32'h80112233,
                  1'b1, 1'b0, 32'h100, 4'hC, 32'h0,
                  1'b1, 2'b00, 5'd9, 32'h00008011, 32'h102, 32'h114, 1'b0};
        v[5]  = '{1'b1, 2'b00, 5'd10, 1'b0, 3'b000, 32'h101, 32'h0, 32'h118, 32'h80112233,
                  1'b1, 1'b0, 32'h100, 4'h2, 32'h0,
                  1'b1, 2'b00, 5'd10, 32'h00000022, 32'h101, 32'h118, 1'b0};
        v[6]  = '{1'b1, 2'b00, 5'd11, 1'b0, 3'b110, 32'h104, 32'h0, 32'h11C, 32'hCAFEF00D,
                  1'b1, 1'b0, 32'h104, 4'hF, 32'h0,
                  1'b1, 2'b00, 5'd11, 32'hCAFEF00D, 32'h104, 32'h11C, 1'b0};
        v[7]  = '{1'b0, 2'b00, 5'd0, 1'b1, 3'b010, 32'h200, 32'h12345678, 32'h20, 32'hFFFFFFFF,
                  1'b1, 1'b1, 32'h200, 4'hF, 32'h12345678,
                  1'b0, 2'b00, 5'd0, 32'h0, 32'h200, 32'h20, 1'b0};
        v[8]  = '{1'b0, 2'b00, 5'd0, 1'b1, 3'b001, 32'h206, 32'h0000BEEF, 32'h24, 32'hFFFFFFFF,
                  1'b1, 1'b1, 32'h204, 4'hC, 32'hBEEFBEEF,
                  1'b0, 2'b00, 5'd0, 32'h0, 32'h206, 32'h24, 1'b0};
        v[9]  = '{1'b0, 2'b00, 5'd0, 1'b1, 3'b000, 32'h202, 32'h123456CD, 32'h28, 32'hFFFFFFFF,
                  1'b1, 1'b1, 32'h200, 4'h4, 32'hCDCDCDCD,
                  1'b0, 2'b00, 5'd0, 32'h0, 32'h202, 32'h28, 1'b0};
        v[10] = '{1'b1, 2'b01, 5'd7, 1'b0, 3'b010, 32'h55, 32'h0, 32'h40, 32'hFFFFFFFF,
                  1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
                  1'b1, 2'b01, 5'd7, 32'h0, 32'h55, 32'h40, 1'b0};
        v[11] = '{1'b1, 2'b10, 5'd1, 1'b0, 3'b000, 32'h2000, 32'h0, 32'h1008, 32'hFFFFFFFF,
                  1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
                  1'b1, 2'b10, 5'd1, 32'h0, 32'h2000, 32'h1008, 1'b0};
        v[12] = '{1'b1, 2'b00, 5'd5, 1'b0, 3'b010, 32'h102, 32'h0, 32'h12C, 32'hDEADBEEF,
                  1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
                  1'b0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1};
        v[13] = '{1'b1, 2'b00, 5'd3, 1'b0, 3'b001, 32'h101, 32'h0, 32'h130, 32'hDEADBEEF,
                  1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
                  1'b0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1};
        v[14] = '{1'b0, 2'b00, 5'd0, 1'b1, 3'b010, 32'h203, 32'hCAFEBABE, 32'h134, 32'h0,
                  1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
                  1'b0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1};
        v[15] = '{1'b1, 2'b00, 5'd31, 1'b0, 3'b100, 32'h3, 32'h0, 32'h8, 32'hA5000000,
                  1'b1, 1'b0, 32'h0, 4'h8, 32'h0,
                  1'b1, 2'b00, 5'd31, 32'h000000A5, 32'h3, 32'h8, 1'b0};

        // Reset state
        rst = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        set_m(1'b0, 2'b00, 5'd0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_regwriteW", 32'(regwriteW), 32'd0);
        check("rst_wbselW", 32'(wbselW), 32'd0);
        check("rst_rdW", 32'(rdW), 32'd0);
        check("rst_data_readW", data_readW, 32'd0);
        check("rst_ALUresW", ALUresW, 32'd0);
        check("rst_pc4W", pc4W, 32'd0);
        check("rst_flags", {30'd0, misalignW, buserrW}, 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(stallM), 32'd0);
        rst = 1'b0;

        // Table: single-cycle accesses with ready in the issue cycle
        for (int i = 0; i < 16; i++) begin
            set_m(v[i].rw, v[i].wb, v[i].rd, v[i].mw, v[i].f3,
                  v[i].alu, v[i].wd, v[i].pc4);
            dmem_rdata = v[i].rdata;
            dmem_ready = 1'b1;
            #1;
            check($sformatf("v%0d_req", i), 32'(dmem_req), 32'(v[i].e_req));
            check($sformatf("v%0d_stall", i), 32'(stallM), 32'd0);
            if (v[i].e_req) begin
                check($sformatf("v%0d_we", i), 32'(dmem_we), 32'(v[i].e_we));
                check($sformatf("v%0d_addr", i), dmem_addr, v[i].e_addr);
                check($sformatf("v%0d_be", i), 32'(dmem_be), 32'(v[i].e_be));
                if (v[i].e_we)
                    check($sformatf("v%0d_wdata", i), dmem_wdata, v[i].e_wdata);
            end
            tick();
            check($sformatf("v%0d_regwriteW", i), 32'(regwriteW), 32'(v[i].e_rw));
            check($sformatf("v%0d_wbselW", i), 32'(wbselW), 32'(v[i].e_wb));
            check($sformatf("v%0d_rdW", i), 32'(rdW), 32'(v[i].e_rd));
            check($sformatf("v%0d_data_readW", i), data_readW, v[i].e_data);
            check($sformatf("v%0d_ALUresW", i), ALUresW, v[i].e_alu);
            check($sformatf("v%0d_pc4W", i), pc4W, v[i].e_pc4);
            check($sformatf("v%0d_misalignW", i), 32'(misalignW), 32'(v[i].e_mis));
            check($sformatf("v%0d_buserrW", i), 32'(buserrW), 32'd0);
        end

        // SB with ready after three cycles
        set_m(1'b0, 2'b00, 5'd0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h50);
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        stalls = 0;
        bubbles = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("sb_c%0d_req", i), 32'(dmem_req), 32'd1);
            check($sformatf("sb_c%0d_we", i), 32'(dmem_we), 32'd1);
            check($sformatf("sb_c%0d_addr", i), dmem_addr, 32'h100);
            check($sformatf("sb_c%0d_be", i), 32'(dmem_be), 32'h2);
            check($sformatf("sb_c%0d_wdata", i), dmem_wdata, 32'hABABABAB);
            if (stallM) stalls++;
            tick();
            if (wbselW == 2'b11 && !regwriteW && rdW == 5'd0) bubbles++;
        end
        dmem_ready = 1'b1;
        #1;
        check("sb_done_req", 32'(dmem_req), 32'd1);
        check("sb_done_stall", 32'(stallM), 32'd0);
        tick();
        dmem_ready = 1'b0;
        check("sb_stall_cycles", 32'(stalls), 32'd3);
        check("sb_bubbles", 32'(bubbles), 32'd3);
        check("sb_w_alu", ALUresW, 32'h101);
        check("sb_w_wbsel", 32'(wbselW), 32'd0);
        check("sb_w_regwrite", 32'(regwriteW), 32'd0);

        // LW that never gets ready: timeout
        set_m(1'b1, 2'b00, 5'd12, 1'b0, 3'b010, 32'h300, 32'h0, 32'h304);
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stallM) begin
                got = 1'b1;
                break;
            end
            cnt++;
            tick();
        end
        if (got) begin
            check("to_stall_cycles", 32'(cnt), 32'd16);
            check("to_req_held", 32'(dmem_req), 32'd1);
            tick();
            check("to_buserrW", 32'(buserrW), 32'd1);
            check("to_regwriteW", 32'(regwriteW), 32'd0);
            check("to_wbselW", 32'(wbselW), 32'h3);
            check("to_misalignW", 32'(misalignW), 32'd0);
            set_m(1'b1, 2'b01, 5'd2, 1'b0, 3'b000, 32'h77, 32'h0, 32'h60);
            tick();
            check("to_buserr_clear", 32'(buserrW), 32'd0);
            check("to_next_rd", 32'(rdW), 32'd2);
        end else begin
            check("to_bound", 32'd0, 32'd1);
        end

        // Ready in the timeout cycle completes normally
        set_m(1'b1, 2'b00, 5'd13, 1'b0, 3'b010, 32'h304, 32'h0, 32'h308);
        dmem_rdata = 32'h13572468;
        dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (!stallM) break;
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        check("rw_stall", 32'(stallM), 32'd0);
        tick();
        dmem_ready = 1'b0;
        check("rw_regwriteW", 32'(regwriteW), 32'd1);
        check("rw_data", data_readW, 32'h13572468);
        check("rw_rdW", 32'(rdW), 32'd13);
        check("rw_buserrW", 32'(buserrW), 32'd0);

        // Reset in WAIT cycle 2, with ready in the same cycle
        set_m(1'b1, 2'b00, 5'd14, 1'b0, 3'b010, 32'h400, 32'h0, 32'h404);
        dmem_rdata = 32'h11111111;
        tick();
        check("rw2_wait_stall", 32'(stallM), 32'd1);
        tick();
        rst = 1'b1;
        dmem_ready = 1'b1;
        tick();
        rst = 1'b0;
        dmem_ready = 1'b0;
        set_m(1'b0, 2'b00, 5'd0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        check("mr_regwriteW", 32'(regwriteW), 32'd0);
        check("mr_wbselW", 32'(wbselW), 32'd0);
        check("mr_rdW", 32'(rdW), 32'd0);
        check("mr_data", data_readW, 32'd0);
        check("mr_alu_pc4", ALUresW | pc4W, 32'd0);
        check("mr_flags", {30'd0, misalignW, buserrW}, 32'd0);
        #1;
        check("mr_req", 32'(dmem_req), 32'd0);
        check("mr_stall", 32'(stallM), 32'd0);
        set_m(1'b1, 2'b00, 5'd15, 1'b0, 3'b010, 32'h404, 32'h0, 32'h408);
        dmem_rdata = 32'h2468ACE0;
        dmem_ready = 1'b1;
        #1;
        check("mr_idle_stall", 32'(stallM), 32'd0);
        check("mr_idle_addr", dmem_addr, 32'h404);
        tick();
        dmem_ready = 1'b0;
        check("mr_idle_data", data_readW, 32'h2468ACE0);
        check("mr_idle_rdW", 32'(rdW), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of WAIT cycles without dmem_ready before an access aborts.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 regwriteM input 1, wbselM input 2, rdM input 5, memwriteM input 1, funct3M input 3 SHALL be the M-stage control fields.
REQ-005 ALUresM input 32 (address/result), writedataM input 32 (store data), pc4M input 32 SHALL be the M-stage data fields.
REQ-006 dmem_req output 1, dmem_we output 1, dmem_addr output 32 (word-aligned), dmem_be output 4, dmem_wdata output 32 SHALL form the data-memory request.
REQ-007 dmem_rdata input 32 and dmem_ready input 1 SHALL form the data-memory response.
REQ-008 stallM output 1 SHALL hold all upstream stages while high.
REQ-009 regwriteW output 1, wbselW output 2, rdW output 5, data_readW/ALUresW/pc4W output 32 each SHALL be the registered MEM/WB fields consumed by writeback.
REQ-010 misalignW output 1 and buserrW output 1 SHALL be registered one-cycle fault flags aligned with the faulting instruction in W.

Function
REQ-011 A load SHALL be wbselM==00 with regwriteM=1; a store SHALL be memwriteM=1; all else is non-memory and passes M->W in one cycle.
REQ-012 FSM SHALL have states IDLE and WAIT.
REQ-013 IDLE with an aligned load/store: dmem_req=1 combinationally; dmem_ready=1 the same cycle completes it (zero wait, stallM=0); else go to WAIT, stallM=1.
REQ-014 WAIT: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata SHALL stay stable, stallM=1, wait counter increments per cycle; dmem_ready=1 completes the access, returns to IDLE, stallM=0 that cycle.
REQ-015 Counter reaching TIMEOUT_CYCLES in WAIT without ready SHALL abort: return to IDLE, release stall, write a bubble with buserrW=1.
REQ-016 Completing and timeout cycles SHALL be the same cycle; dmem_ready in the timeout cycle wins (normal completion).
REQ-017 Every stalled cycle SHALL load a bubble into W: regwriteW=0, wbselW=11, rdW=0, data fields 0, flags 0.
REQ-018 dmem_addr SHALL be {ALUresM[31:2],2'b00}; dmem_be: byte=1<<a[1:0], half=4'b0011<<a[1:0], word=4'b1111.
REQ-019 Store data SHALL be replicated into lanes: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
REQ-020 Load data SHALL be extracted by a[1:0] and extended: LB/LH sign, LBU/LHU zero, LW raw; funct3 011/110/111 treated as LW.
REQ-021 Misaligned access (half with a[0]=1, word with a[1:0]!=0) SHALL issue no dmem_req and SHALL pass through in one cycle as a bubble (regwriteW=0) with misalignW=1.
REQ-022 Non-load instructions SHALL give data_readW=0; ALUresW, pc4W, rdW, wbselW, regwriteW SHALL copy M values on every non-stalled cycle.
REQ-023 A request in flight SHALL never be dropped or duplicated by stallM.

Reset
REQ-024 rst SHALL force state IDLE, counter 0, all W outputs and flags 0 (wbselW=00), dmem_req=0, stallM=0 on the next edge, also mid-WAIT.
REQ-025 rst SHALL dominate dmem_ready in the same cycle; the pending access is discarded without a write to W.

Structure
REQ-026 Shared package SHALL hold the FSM state enum, funct3 load/store encodings, wbsel encodings (00 mem, 01 ALU, 10 pc4), and the bubble value.
REQ-027 One sub-module, load_align (combinational: rdata, a[1:0], funct3 -> extended data), SHALL be instantiated; FSM, counter and MEM/WB register remain in memory_stage.

Verification
REQ-028 LW a=0x100, ready same cycle, rdata=0xDEADBEEF -> no stall, next cycle data_readW=0xDEADBEEF, regwriteW=1, rdW copied.
REQ-029 LB a=0x103, rdata=0x80112233 -> data_readW=0xFFFFFF80; LBU -> 0x00000080; LH a=0x102 -> 0xFFFF8011.
REQ-030 SB a=0x101, wd=0x000000AB, ready after 3 cycles -> dmem_be=0010, wdata=0xABABABAB, stallM=1 for 3 cycles, 3 bubbles in W, stable request.
REQ-031 LW a=0x102 -> no dmem_req, regwriteW=0, misalignW=1 for one cycle.
REQ-032 LW, ready never asserted, TIMEOUT_CYCLES=16 -> stall released after 16 WAIT cycles, buserrW=1 one cycle, regwriteW=0.
REQ-033 rst asserted in WAIT cycle 2 -> next cycle IDLE, dmem_req=0, stallM=0, all W outputs 0.
